// File: rtl/store_watch_pkg.sv
// Shared types and default constants for the store-watch FIFO block.
package store_watch_pkg;

    localparam int          N_DEF          = 32;
    localparam logic [31:0] MMIO_BASE_DEF  = 32'h0000_0040;
    localparam logic [31:0] MMIO_SIZE_DEF  = 32'h0000_0040;
    localparam logic [31:0] HALT_ADDR_DEF  = 32'd84;
    localparam logic [31:0] HALT_VALUE_DEF = 32'h0000_0096;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [N_DEF-1:0] addr;
        logic [N_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/store_watch_fifo_sync_fifo.sv
// First-word-fall-through FIFO with a registered head; accepts push+pop together when full.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             valid,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wrPtr_r;
    logic [AW-1:0]    rdPtr_r;
    logic [AW-1:0]    rdPtrNext_s;
    logic [CW-1:0]    countNext_s;
    logic [CW-1:0]    remain_s;
    logic [WIDTH-1:0] headNext_s;
    logic             doPop_s;
    logic             doPush_s;
    logic             full_s;

    // Next-state computation for pointers, occupancy and the head register
    always_comb begin
        full_s      = (count == CW'(DEPTH));
        doPop_s     = pop && (count != '0);
        doPush_s    = push && (!full_s || doPop_s);
        rdPtrNext_s = doPop_s ? (rdPtr_r + AW'(1)) : rdPtr_r;
        remain_s    = count - CW'(doPop_s);
        countNext_s = remain_s + CW'(doPush_s);
        // An entry pushed into an otherwise empty queue bypasses the array into the head
        if (countNext_s == '0) begin
            headNext_s = rdData;
        end else if (remain_s == '0) begin
            headNext_s = wrData;
        end else begin
            headNext_s = mem_r[rdPtrNext_s];
        end
    end

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            mem_r[wrPtr_r] <= wrData;
        end
    end

    // Pointer, occupancy and registered head/valid update
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count   <= '0;
            valid   <= 1'b0;
            rdData  <= '0;
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + AW'(1);
            end
            rdPtr_r <= rdPtrNext_s;
            count   <= countNext_s;
            valid   <= (countNext_s != '0);
            rdData  <= headNext_s;
        end
    end

    assign full = full_s;

endmodule

// File: rtl/store_watch_fifo.sv
// Snoops CPU stores, buffers those hitting the MMIO window and flags the halt store.
module store_watch_fifo
    import store_watch_pkg::*;
#(
    parameter int           n          = N_DEF,
    parameter int           DEPTH      = 4,
    parameter logic [n-1:0] MMIO_BASE  = n'(MMIO_BASE_DEF),
    parameter logic [n-1:0] MMIO_SIZE  = n'(MMIO_SIZE_DEF),
    parameter logic [n-1:0] HALT_ADDR  = n'(HALT_ADDR_DEF),
    parameter logic [n-1:0] HALT_VALUE = n'(HALT_VALUE_DEF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memWrite,
    input  logic [n-1:0]             dataAddr,
    input  logic [n-1:0]             writeData,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [n-1:0]             out_addr,
    output logic [n-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     misaligned,
    output logic                     done,
    output logic                     idle,
    output logic [15:0]              store_cnt
);

    state_t       state_r;
    logic [n:0]   addrExt_s;
    logic [n:0]   winEnd_s;
    logic         hit_s;
    logic         aligned_s;
    logic         run_s;
    logic         pushReq_s;
    logic         haltHit_s;
    logic         drop_s;
    logic         full_s;
    logic [2*n-1:0] head_s;

    // Window decode in n+1 bits so a window ending exactly at 2^n still works
    always_comb begin
        addrExt_s = {1'b0, dataAddr};
        winEnd_s  = {1'b0, MMIO_BASE} + {1'b0, MMIO_SIZE};
        hit_s     = memWrite && (addrExt_s >= {1'b0, MMIO_BASE}) && (addrExt_s < winEnd_s);
        aligned_s = (dataAddr[1:0] == 2'b00);
        run_s     = (state_r == RUN);
        pushReq_s = run_s && hit_s && aligned_s;
        haltHit_s = run_s && memWrite && (dataAddr == HALT_ADDR) && (writeData == HALT_VALUE);
        drop_s    = pushReq_s && full_s && !out_ready;
    end

    sync_fifo #(
        .WIDTH (2*n),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (pushReq_s),
        .pop    (out_ready),
        .wrData ({dataAddr, writeData}),
        .rdData (head_s),
        .valid  (out_valid),
        .full   (full_s),
        .count  (count)
    );

    assign out_addr = head_s[2*n-1:n];
    assign out_data = head_s[n-1:0];
    assign idle     = done && (count == '0);

    // RUN/HALTED state machine; HALTED is left only through reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
            done    <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (haltHit_s) begin
                        state_r <= HALTED;
                        done    <= 1'b1;
                    end
                end
                HALTED: begin
                    state_r <= HALTED;
                    done    <= 1'b1;
                end
                default: begin
                    state_r <= RUN;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags and the saturating store counter
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            misaligned <= 1'b0;
            store_cnt  <= 16'h0000;
        end else begin
            if (drop_s) begin
                overflow <= 1'b1;
            end
            if (run_s && hit_s && !aligned_s) begin
                misaligned <= 1'b1;
            end
            if (memWrite && (store_cnt != 16'hFFFF)) begin
                store_cnt <= store_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/store_watch_fifo.md
Name: store_watch_fifo

Overview:
Sits directly downstream of the computer's data-memory write port and snoops every store (memWrite, dataAddr, writeData) the CPU issues. Stores that fall in a memory-mapped I/O window are buffered in a small FIFO and drained over a valid/ready stream to a console/log consumer. A store of a programmed signature to a halt address stops capture and raises done, so benches and top-levels get a hardware "program finished" indication.

Parameters:
n, 32, data/address width (matches computer bus)
DEPTH, 4, FIFO entries (power of two, >=2)
MMIO_BASE, 32'h40, first byte address of watched window
MMIO_SIZE, 32'h40, window size in bytes (window = [BASE, BASE+SIZE))
HALT_ADDR, 32'd84, halt-trigger address
HALT_VALUE, 32'h96, halt-trigger data value

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
memWrite  in  1  store strobe from computer
dataAddr  in  n  store byte address
writeData  in  n  store data
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head this cycle
out_addr  out  n  address of head entry
out_data  out  n  data of head entry
count  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: an in-window store was dropped
misaligned  out  1  sticky: in-window store with dataAddr[1:0]!=0
done  out  1  halt store seen (state HALTED)
idle  out  1  done && FIFO empty
store_cnt  out  16  saturating count of all memWrite cycles

Behaviour:
- Reset (sync, active-high, on posedge clk): FIFO emptied, pointers 0, count=0, out_valid=0, out_addr=out_data=0, overflow=0, misaligned=0, done=0, idle=0, store_cnt=0, state=RUN. Reset asserted mid-operation discards all buffered entries, no drain.
- hit = memWrite && dataAddr>=MMIO_BASE && dataAddr<MMIO_BASE+MMIO_SIZE (unsigned, n-bit compare; BASE+SIZE computed in n+1 bits so window may touch 2^n).
- Misaligned hit: not pushed; misaligned<=1.
- FSM RUN: aligned hit -> push {dataAddr, writeData}. memWrite && dataAddr==HALT_ADDR && writeData==HALT_VALUE -> HALTED next cycle; that same store is still pushed if it is an aligned hit.
- FSM HALTED: no further pushes (hits ignored, overflow not set); FIFO keeps draining; leaves only on reset. done=1 in HALTED; idle=HALTED && count==0.
- Push latency: store at posedge k visible as out_valid=1 with that entry after posedge k (registered, first-word-fall-through).
- Pop: out_valid && out_ready at posedge removes head; out_ready with out_valid=0 ignored.
- Full (count==DEPTH): push with simultaneous pop accepted (count unchanged); push without pop dropped, overflow<=1, FIFO unchanged.
- Empty + push + out_ready same cycle: no pop (head not yet valid); count becomes 1.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH.
- store_cnt increments on every memWrite cycle regardless of address/state, saturates at 16'hFFFF.
- out_addr/out_data hold last head value when out_valid=0 (don't-care for checkers).

Decomposition:
- Package store_watch_pkg: state enum {RUN, HALTED}; default MMIO_BASE/MMIO_SIZE/HALT_ADDR/HALT_VALUE constants; entry struct {addr[n], data[n]}.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count, same-cycle push+pop when full). Top holds window decode, FSM, sticky flags, store_cnt.

Test Plan:
- Reset then 3 stores to 0x40,0x44,0x48 data 1,2,3, out_ready=0 -> count=3, out_valid=1, head {0x40,1}; raise out_ready -> pops 1,2,3 in order, count=0.
- Store to 0x20 and 0x80 (outside window) -> no push, count=0, store_cnt=2.
- DEPTH=4: 5 in-window stores, out_ready=0 -> count=4, overflow=1, 5th lost; repeat full with out_ready=1 on push cycle -> accepted, overflow unchanged otherwise.
- Store 0x96 to 84 (0x54, in window) -> pushed {0x54,0x96}, done=1 next cycle; later store to 0x44 ignored; after draining idle=1. Store 0x95 to 84 -> done stays 0.
- Store to 0x42 -> misaligned=1, count unchanged.
- 2 entries buffered, done=1, assert reset one cycle -> count=0, out_valid=0, done=0, all sticky flags 0, store_cnt=0.
